// File: rtl/lane_delay_ring.sv
// Sample storage ring for lane_delay_ctrl: one write per cycle, and a read tap
// at a programmable distance behind the write pointer.
module lane_delay_ring #(
    parameter int WIDTH     = 32,
    parameter int MAX_DELAY = 16,
    parameter int AW        = $clog2(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    input  logic [AW-1:0]    i_delay,   // delay mod MAX_DELAY; 0 means MAX_DELAY
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [AW-1:0]    r_wr_ptr;
    logic [MAX_DELAY-1:0] r_valid;
    logic [WIDTH-1:0] r_mem [MAX_DELAY];
    logic [AW-1:0]    w_rd_idx;

    // Read happens before write: with a full-depth delay the tap sits on the
    // entry that is about to be overwritten, which is the oldest sample.
    assign w_rd_idx = r_wr_ptr - i_delay;
    assign o_valid  = r_valid[w_rd_idx];
    assign o_data   = r_mem[w_rd_idx];

    // NOTE: non-blocking assignments make the pointer and valid bits update together at the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_valid  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_clr) begin
                r_valid <= '0;
            end else begin
                r_valid[r_wr_ptr] <= i_valid;
            end
        end
    end

    // NOTE: the data array is not reset; the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/lane_delay_ctrl.sv
// Per-lane programmable delay line with a reconfiguration sequencer that
// blanks stale samples while a new delay fills the ring.
module lane_delay_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MAX_DELAY   = 16,
    parameter int RESET_DELAY = 4,
    localparam int DW         = $clog2(MAX_DELAY) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic [DW-1:0]    cfg_delay,
    input  logic             cfg_req,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [DW-1:0]    active_delay
);

    localparam int            AW    = $clog2(MAX_DELAY);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
    localparam logic [DW-1:0] RST_D = DW'(RESET_DELAY);

    typedef enum logic {ST_RUN, ST_FILL} state_t;

    if ((MAX_DELAY < 2) || ((MAX_DELAY & (MAX_DELAY - 1)) != 0)) begin : g_bad_max_delay
        $error("lane_delay_ctrl: MAX_DELAY must be a power of two and at least 2");
    end
    if ((RESET_DELAY < 1) || (RESET_DELAY > MAX_DELAY)) begin : g_bad_reset_delay
        $error("lane_delay_ctrl: RESET_DELAY must lie in 1..MAX_DELAY");
    end

    state_t           r_state;
    logic [DW-1:0]    r_active_delay;
    logic [DW-1:0]    r_fill_cnt;
    logic             r_cfg_ready;
    logic             r_cfg_done;
    logic             r_cfg_err;
    logic             w_legal;
    logic             w_accept;
    logic [DW-1:0]    w_fill_dec;
    logic             w_ring_valid;
    logic [WIDTH-1:0] w_ring_data;

    assign w_legal    = (cfg_delay != '0) && (cfg_delay <= MAX_D);
    assign w_accept   = cfg_req && (r_state == ST_RUN) && w_legal;
    assign w_fill_dec = r_fill_cnt - 1'b1;

    // The clear also drops the sample written on the accepting edge.
    lane_delay_ring #(
        .WIDTH     (WIDTH),
        .MAX_DELAY (MAX_DELAY),
        .AW        (AW)
    ) u_ring (
        .clk     (clk),
        .resetn  (resetn),
        .i_data  (in_data),
        .i_valid (in_valid),
        .i_delay (r_active_delay[AW-1:0]),
        .i_clr   (w_accept),
        .o_data  (w_ring_data),
        .o_valid (w_ring_valid)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_RUN;
            r_active_delay <= RST_D;
            r_fill_cnt     <= '0;
            r_cfg_ready    <= 1'b1;
            r_cfg_done     <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            r_cfg_done <= 1'b0;
            r_cfg_err  <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (cfg_req) begin
                        if (w_legal) begin
                            r_active_delay <= cfg_delay;
                            r_fill_cnt     <= cfg_delay;
                            r_cfg_ready    <= 1'b0;
                            r_state        <= ST_FILL;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    r_fill_cnt <= w_fill_dec;
                    if (w_fill_dec == '0) begin
                        r_cfg_ready <= 1'b1;
                        r_cfg_done  <= 1'b1;
                        r_state     <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Data is zeroed whenever it is not qualified so the output stays deterministic.
    assign out_valid    = w_ring_valid && (r_state == ST_RUN);
    assign out_data     = out_valid ? w_ring_data : '0;
    assign cfg_ready    = r_cfg_ready;
    assign cfg_done     = r_cfg_done;
    assign cfg_err      = r_cfg_err;
    assign active_delay = r_active_delay;

endmodule

// File: tb/tb_lane_delay_ctrl.sv
// Self-checking bench for lane_delay_ctrl against a timeline model built from
// the input history and the accepted-request edge.
module tb_lane_delay_ctrl;

    localparam int WIDTH       = 32;
    localparam int MAX_DELAY   = 16;
    localparam int RESET_DELAY = 4;
    localparam int DW          = 5;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [DW-1:0]    cfg_delay = '0;
    logic             cfg_req = 1'b0;
    logic             cfg_ready;
    logic             cfg_done;
    logic             cfg_err;
    logic [DW-1:0]    active_delay;

    always #5 clk = ~clk;

    lane_delay_ctrl #(
        .WIDTH       (WIDTH),
        .MAX_DELAY   (MAX_DELAY),
        .RESET_DELAY (RESET_DELAY)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .cfg_delay    (cfg_delay),
        .cfg_req      (cfg_req),
        .cfg_ready    (cfg_ready),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .active_delay (active_delay)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: history of sampled inputs indexed by edge number since
    // reset release, plus the edge and delay of the last accepted request.
    int               n;
    int               t_acc;
    int               m_d;
    logic             hv [0:4095];
    logic [WIDTH-1:0] hd [0:4095];
    logic             exp_valid, exp_ready, exp_done, exp_err;
    logic [WIDTH-1:0] exp_data;
    logic [DW-1:0]    exp_active;

    task automatic model_reset();
        n          = 0;
        t_acc      = -1000;
        m_d        = RESET_DELAY;
        exp_ready  = 1'b1;
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        exp_valid  = 1'b0;
        exp_data   = '0;
        exp_active = DW'(RESET_DELAY);
    endtask

    // One clock: sample inputs at the edge, update expectations, return at negedge.
    task automatic tick();
        int s;
        @(posedge clk);
        n++;
        hv[n]   = in_valid;
        hd[n]   = in_data;
        exp_err = 1'b0;
        if (cfg_req && exp_ready) begin
            if (cfg_delay >= 1 && cfg_delay <= MAX_DELAY) begin
                t_acc = n;
                m_d   = int'(cfg_delay);
            end else begin
                exp_err = 1'b1;
            end
        end
        exp_ready  = !(n >= t_acc && n < t_acc + m_d);
        exp_done   = (n == t_acc + m_d);
        exp_active = DW'(m_d);
        s          = n + 1 - m_d;
        exp_valid  = 1'b0;
        exp_data   = '0;
        if (exp_ready && s >= 1 && s > t_acc) begin
            exp_valid = hv[s];
            exp_data  = hd[s];
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic [DW-1:0] cd);
        in_valid  = v;
        in_data   = d;
        cfg_req   = r;
        cfg_delay = cd;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_cfg_done: got %b expected 0", cfg_done); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
        checks++; if (active_delay !== DW'(RESET_DELAY)) begin errors++; $display("FAIL reset_active_delay: got %0d expected %0d", active_delay, RESET_DELAY); end
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset_delay();
        int first_out = -1;
        logic [WIDTH-1:0] first_data = '0;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, WIDTH'(k), 1'b0, '0);
            tick();
            checks++; if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin errors++; $display("FAIL rst_delay_stream n=%0d: got v=%b d=%h expected v=%b d=%h", n, out_valid, out_data, exp_valid, exp_data); end
            checks++; if ({cfg_ready, cfg_done, cfg_err, active_delay} !== {exp_ready, exp_done, exp_err, exp_active}) begin errors++; $display("FAIL rst_delay_cfg n=%0d: got rdy/done/err/act=%b%b%b/%0d expected %b%b%b/%0d", n, cfg_ready, cfg_done, cfg_err, active_delay, exp_ready, exp_done, exp_err, exp_active); end
            if (out_valid === 1'b1 && first_out < 0) begin
                first_out  = n;
                first_data = out_data;
            end
        end
        checks++; if (first_out != 4) begin errors++; $display("FAIL rst_delay_first_edge: got %0d expected 4", first_out); end
        checks++; if (first_data !== 32'd1) begin errors++; $display("FAIL rst_delay_first_data: got %h expected 1", first_data); end
    endtask

    task automatic test_reconfig_9();
        int acc;
        int low_cnt = 0;
        int done_edge = -1;
        logic [WIDTH-1:0] done_data = '0;
        logic done_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, $urandom, 1'b0, '0);
            tick();
        end
        drive(1'b1, $urandom, 1'b1, 5'd9);
        tick();
        acc = n;
        if (cfg_ready === 1'b0) low_cnt++;
        for (int k = 0; k < 30; k++) begin
            drive(1'b1, $urandom, 1'b0, '0);
            tick();
            checks++; if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin errors++; $display("FAIL cfg9_stream n=%0d: got v=%b d=%h expected v=%b d=%h", n, out_valid, out_data, exp_valid, exp_data); end
            checks++; if ({cfg_ready, cfg_done, cfg_err, active_delay} !== {exp_ready, exp_done, exp_err, exp_active}) begin errors++; $display("FAIL cfg9_cfg n=%0d: got rdy/done/err/act=%b%b%b/%0d expected %b%b%b/%0d", n, cfg_ready, cfg_done, cfg_err, active_delay, exp_ready, exp_done, exp_err, exp_active); end
            if (cfg_ready === 1'b0) low_cnt++;
            if (cfg_done === 1'b1 && done_edge < 0) begin
                done_edge  = n;
                done_data  = out_data;
                done_valid = out_valid;
            end
        end
        checks++; if (low_cnt != 9) begin errors++; $display("FAIL cfg9_ready_low: got %0d cycles expected 9", low_cnt); end
        checks++; if (done_edge != acc + 9) begin errors++; $display("FAIL cfg9_done_edge: got %0d expected %0d", done_edge, acc + 9); end
        checks++; if (done_valid !== 1'b1 || done_data !== hd[acc + 1]) begin errors++; $display("FAIL cfg9_first_sample: got v=%b d=%h expected v=1 d=%h", done_valid, done_data, hd[acc + 1]); end
    endtask

    task automatic test_shrink();
        int low_cnt = 0;
        drive(1'b1, $urandom, 1'b1, 5'd16);
        tick();
        for (int k = 0; k < 24; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 1'b0, '0);
            tick();
            checks++; if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin errors++; $display("FAIL d16_stream n=%0d: got v=%b d=%h expected v=%b d=%h", n, out_valid, out_data, exp_valid, exp_data); end
        end
        drive(1'b1, $urandom, 1'b1, 5'd1);
        tick();
        if (cfg_ready === 1'b0) low_cnt++;
        for (int k = 0; k < 14; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 1'b0, '0);
            tick();
            checks++; if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin errors++; $display("FAIL shrink_stream n=%0d: got v=%b d=%h expected v=%b d=%h", n, out_valid, out_data, exp_valid, exp_data); end
            checks++; if ({cfg_ready, cfg_done, cfg_err, active_delay} !== {exp_ready, exp_done, exp_err, exp_active}) begin errors++; $display("FAIL shrink_cfg n=%0d: got rdy/done/err/act=%b%b%b/%0d expected %b%b%b/%0d", n, cfg_ready, cfg_done, cfg_err, active_delay, exp_ready, exp_done, exp_err, exp_active); end
            if (cfg_ready === 1'b0) low_cnt++;
        end
        checks++; if (low_cnt != 1) begin errors++; $display("FAIL shrink_fill_len: got %0d cycles expected 1", low_cnt); end
    endtask

    task automatic test_illegal();
        logic [DW-1:0] bad [2];
        bad[0] = 5'd0;
        bad[1] = 5'd17;
        for (int b = 0; b < 2; b++) begin
            drive(1'b1, $urandom, 1'b1, bad[b]);
            tick();
            checks++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || cfg_done !== 1'b0) begin errors++; $display("FAIL illegal_%0d_pulse: got err=%b rdy=%b done=%b expected err=1 rdy=1 done=0", bad[b], cfg_err, cfg_ready, cfg_done); end
            checks++; if (active_delay !== 5'd1) begin errors++; $display("FAIL illegal_%0d_active: got %0d expected 1", bad[b], active_delay); end
            for (int k = 0; k < 6; k++) begin
                drive($urandom_range(0, 3) != 0, $urandom, 1'b0, '0);
                tick();
                checks++; if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin errors++; $display("FAIL illegal_stream n=%0d: got v=%b d=%h expected v=%b d=%h", n, out_valid, out_data, exp_valid, exp_data); end
                checks++; if ({cfg_ready, cfg_done, cfg_err, active_delay} !== {exp_ready, exp_done, exp_err, exp_active}) begin errors++; $display("FAIL illegal_cfg n=%0d: got rdy/done/err/act=%b%b%b/%0d expected %b%b%b/%0d", n, cfg_ready, cfg_done, cfg_err, active_delay, exp_ready, exp_done, exp_err, exp_active); end
            end
        end
    endtask

    task automatic test_held_req();
        int acc1;
        drive(1'b1, $urandom, 1'b1, 5'd5);
        tick();
        acc1 = n;
        for (int k = 0; k < 20 && t_acc == acc1; k++) begin
            drive($urandom_range(0, 2) != 0, $urandom, 1'b1, 5'd12);
            tick();
            checks++; if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin errors++; $display("FAIL held_stream n=%0d: got v=%b d=%h expected v=%b d=%h", n, out_valid, out_data, exp_valid, exp_data); end
            checks++; if ({cfg_ready, cfg_done, cfg_err, active_delay} !== {exp_ready, exp_done, exp_err, exp_active}) begin errors++; $display("FAIL held_cfg n=%0d: got rdy/done/err/act=%b%b%b/%0d expected %b%b%b/%0d", n, cfg_ready, cfg_done, cfg_err, active_delay, exp_ready, exp_done, exp_err, exp_active); end
        end
        for (int k = 0; k < 30; k++) begin
            drive($urandom_range(0, 2) != 0, $urandom, 1'b0, '0);
            tick();
            checks++; if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin errors++; $display("FAIL held2_stream n=%0d: got v=%b d=%h expected v=%b d=%h", n, out_valid, out_data, exp_valid, exp_data); end
            checks++; if ({cfg_ready, cfg_done, cfg_err, active_delay} !== {exp_ready, exp_done, exp_err, exp_active}) begin errors++; $display("FAIL held2_cfg n=%0d: got rdy/done/err/act=%b%b%b/%0d expected %b%b%b/%0d", n, cfg_ready, cfg_done, cfg_err, active_delay, exp_ready, exp_done, exp_err, exp_active); end
        end
    endtask

    task automatic test_reset_mid_fill();
        drive(1'b1, $urandom, 1'b1, 5'd12);
        tick();
        drive(1'b1, $urandom, 1'b0, '0);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        checks++; if ({out_valid, cfg_ready, cfg_done, cfg_err} !== 4'b0100) begin errors++; $display("FAIL midfill_flags: got v/rdy/done/err=%b%b%b%b expected 0100", out_valid, cfg_ready, cfg_done, cfg_err); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL midfill_out_data: got %h expected 0", out_data); end
        checks++; if (active_delay !== DW'(RESET_DELAY)) begin errors++; $display("FAIL midfill_active: got %0d expected %0d", active_delay, RESET_DELAY); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (cfg_done !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL midfill_hold_%0d: got done=%b rdy=%b expected done=0 rdy=1", k, cfg_done, cfg_ready); end
        end
        resetn = 1'b1;
        model_reset();
        for (int k = 0; k < 15; k++) begin
            drive(1'b1, $urandom, 1'b0, '0);
            tick();
            checks++; if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin errors++; $display("FAIL post_reset_stream n=%0d: got v=%b d=%h expected v=%b d=%h", n, out_valid, out_data, exp_valid, exp_data); end
            checks++; if ({cfg_ready, cfg_done, cfg_err, active_delay} !== {exp_ready, exp_done, exp_err, exp_active}) begin errors++; $display("FAIL post_reset_cfg n=%0d: got rdy/done/err/act=%b%b%b/%0d expected %b%b%b/%0d", n, cfg_ready, cfg_done, cfg_err, active_delay, exp_ready, exp_done, exp_err, exp_active); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_delay();
        test_reconfig_9();
        test_shrink();
        test_illegal();
        test_held_req();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
